regwb_arbiter: RTL and testbench

REGWB_ARBITER -- requirements
Module: regwb_arbiter

---
 rtl/regwb_arbiter.sv | 144 ++++++++++++++
 tb/tb_regwb_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regwb_arbiter.sv
// ============================================================================
// regwb_arbiter: two-requester (ALU/LSU) register-file writeback arbiter with
// one-entry holding buffers, age priority and round-robin tie break.
// Optional macro REGWB_CONFLICT_STATS_EN enables the conflict_cnt counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regwb_arbiter #(
  parameter int RADDRWIDTH = 3,
  parameter int REGWIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [RADDRWIDTH-1:0] alu_waddr,
  input  logic [REGWIDTH-1:0]   alu_wdata,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [RADDRWIDTH-1:0] lsu_waddr,
  input  logic [REGWIDTH-1:0]   lsu_wdata,
  output logic                  we,
  output logic [RADDRWIDTH-1:0] waddr,
  output logic [REGWIDTH-1:0]   wdata,
  output logic [(2**RADDRWIDTH)-1:0] pend,
  output logic [15:0]           conflict_cnt
);

  localparam int NREG = 2**RADDRWIDTH;

  logic                  alu_v, lsu_v;
  logic                  alu_age, lsu_age;   // set: this entry is older than the other
  logic                  rr_lsu;
  logic [RADDRWIDTH-1:0] alu_a, lsu_a;
  logic [REGWIDTH-1:0]   alu_d, lsu_d;

  logic gnt_alu, gnt_lsu, tie;
  logic alu_acc, lsu_acc;
  logic nx_alu_v, nx_lsu_v;

  // Grant selection; reset masks everything so pending entries never write.
  always_comb begin
    gnt_alu = 1'b0;
    gnt_lsu = 1'b0;
    tie     = 1'b0;
    if (!rst) begin
      if (alu_v && lsu_v) begin
        if (alu_age != lsu_age) begin
          gnt_alu = alu_age;
          gnt_lsu = lsu_age;
        end else begin
          tie     = 1'b1;
          gnt_lsu = rr_lsu;
          gnt_alu = !rr_lsu;
        end
      end else begin
        gnt_alu = alu_v;
        gnt_lsu = lsu_v;
      end
    end
  end

  assign alu_ready = !rst && (!alu_v || gnt_alu);
  assign lsu_ready = !rst && (!lsu_v || gnt_lsu);
  assign alu_acc   = alu_valid && alu_ready;
  assign lsu_acc   = lsu_valid && lsu_ready;
  assign nx_alu_v  = alu_acc || (alu_v && !gnt_alu);
  assign nx_lsu_v  = lsu_acc || (lsu_v && !gnt_lsu);

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_v   <= 1'b0;
      lsu_v   <= 1'b0;
      alu_age <= 1'b0;
      lsu_age <= 1'b0;
      rr_lsu  <= 1'b1;
    end else begin
      alu_v <= nx_alu_v;
      lsu_v <= nx_lsu_v;
      if (alu_acc) begin
        alu_a <= alu_waddr;
        alu_d <= alu_wdata;
      end
      if (lsu_acc) begin
        lsu_a <= lsu_waddr;
        lsu_d <= lsu_wdata;
      end
      // A fresh load is always the younger entry unless both load together.
      if (alu_acc && lsu_acc) begin
        alu_age <= 1'b0;
        lsu_age <= 1'b0;
      end else if (alu_acc) begin
        alu_age <= 1'b0;
        lsu_age <= nx_lsu_v;
      end else if (lsu_acc) begin
        lsu_age <= 1'b0;
        alu_age <= nx_alu_v;
      end
      if (tie) begin
        rr_lsu <= !rr_lsu;
      end
    end
  end

  always_comb begin
    waddr = '0;
    wdata = '0;
    if (gnt_alu) begin
      waddr = alu_a;
      wdata = alu_d;
    end else if (gnt_lsu) begin
      waddr = lsu_a;
      wdata = lsu_d;
    end
  end

  assign we = (gnt_alu || gnt_lsu) && (waddr != '0);

  assign pend[0] = 1'b0;
  for (genvar i = 1; i < NREG; i++) begin : g_pend
    assign pend[i] = !rst && ((alu_v && (alu_a == RADDRWIDTH'(i))) ||
                              (lsu_v && (lsu_a == RADDRWIDTH'(i))));
  end

`ifdef REGWB_CONFLICT_STATS_EN
  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (alu_v && lsu_v && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign conflict_cnt = cnt;
`else
  assign conflict_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regwb_arbiter.sv
// Directed bench for regwb_arbiter; expected writes are queued at stimulus time
// and popped whenever the DUT asserts we.
`default_nettype none

module tb_regwb_arbiter;

  localparam int AW = 3;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          alu_valid, lsu_valid;
  logic          alu_ready, lsu_ready;
  logic [AW-1:0] alu_waddr, lsu_waddr;
  logic [DW-1:0] alu_wdata, lsu_wdata;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [7:0]    pend;
  logic [15:0]   conflict_cnt;

  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] sb[$];

  regwb_arbiter #(.RADDRWIDTH(AW), .REGWIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
    .we(we), .waddr(waddr), .wdata(wdata), .pend(pend), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Any write seen must be the oldest outstanding expectation.
  task automatic monitor();
    logic [AW+DW-1:0] e;
    if (we === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {13'd0, waddr, wdata}, 32'hDEAD);
      end else begin
        e = sb.pop_front();
        check("wb_addr_data", {13'd0, waddr, wdata}, {13'd0, e});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
  endtask

  int ai, li;
  logic a_go, l_go;
  int exp_conf;

  initial begin
    rst = 1'b1;
    idle();
    alu_waddr = '0; alu_wdata = '0; lsu_waddr = '0; lsu_wdata = '0;
    tick();
    tick();
    check("rst_we", we, 1'b0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_pend", pend, 0);
    check("rst_alu_ready", alu_ready, 1'b0);
    check("rst_lsu_ready", lsu_ready, 1'b0);
    check("rst_conflict", conflict_cnt, 0);

    rst = 1'b0;
    #1;
    check("ready_after_rst_alu", alu_ready, 1'b1);
    check("ready_after_rst_lsu", lsu_ready, 1'b1);

    // Single ALU write: visible exactly one cycle after acceptance.
    alu_valid = 1'b1; alu_waddr = 3; alu_wdata = 16'h1234;
    sb.push_back({3'd3, 16'h1234});
    tick();
    idle();
    check("single_latency_we", we, 1'b1);
    check("single_pend", pend, 8'b0000_1000);
    tick();
    check("single_after_we", we, 1'b0);
    check("single_after_pend", pend, 0);
    check("idle_waddr", waddr, 0);
    check("idle_wdata", wdata, 0);

    // First tie goes to LSU.
    alu_valid = 1'b1; alu_waddr = 2; alu_wdata = 16'hAAAA;
    lsu_valid = 1'b1; lsu_waddr = 5; lsu_wdata = 16'h5555;
    sb.push_back({3'd5, 16'h5555});
    sb.push_back({3'd2, 16'hAAAA});
    tick();
    idle();
    check("tie1_pend", pend, 8'b0010_0100);
    check("tie1_alu_ready", alu_ready, 1'b0);
    tick();
    tick();
    check("tie1_done_we", we, 1'b0);

    // Second tie goes to ALU.
    alu_valid = 1'b1; alu_waddr = 1; alu_wdata = 16'h1111;
    lsu_valid = 1'b1; lsu_waddr = 6; lsu_wdata = 16'h6666;
    sb.push_back({3'd1, 16'h1111});
    sb.push_back({3'd6, 16'h6666});
    tick();
    idle();
    tick();
    tick();

    // Same-address writes keep acceptance order.
    lsu_valid = 1'b1; lsu_waddr = 4; lsu_wdata = 16'h0001;
    sb.push_back({3'd4, 16'h0001});
    tick();
    idle();
    alu_valid = 1'b1; alu_waddr = 4; alu_wdata = 16'h0002;
    sb.push_back({3'd4, 16'h0002});
    tick();
    idle();
    tick();
    tick();
    check("order_drained_pend", pend, 0);

    // Register 0 is consumed silently.
    alu_valid = 1'b1; alu_waddr = 0; alu_wdata = 16'hFFFF;
    #1;
    check("r0_alu_ready", alu_ready, 1'b1);
    tick();
    idle();
    check("r0_we", we, 1'b0);
    check("r0_pend", pend, 0);
    tick();
    check("r0_after_we", we, 1'b0);
    check("r0_alu_ready_after", alu_ready, 1'b1);

    // Reset with both buffers full discards them.
    alu_valid = 1'b1; alu_waddr = 3; alu_wdata = 16'h3333;
    lsu_valid = 1'b1; lsu_waddr = 5; lsu_wdata = 16'h5555;
    @(posedge clk);
    #1;
    idle();
    rst = 1'b1;
    #1;
    check("midrst_we", we, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check("postrst_pend", pend, 0);
    check("postrst_we", we, 1'b0);
    check("postrst_conflict", conflict_cnt, 0);
    tick();
    check("postrst_idle_we", we, 1'b0);

    // Both held valid for 10 edges: LSU wins the opening tie, then age alternates.
    for (int k = 0; k < 6; k++) begin
      sb.push_back({AW'(k % 7 + 1), 16'hB000 + 16'(k)});
      if (k < 5) sb.push_back({AW'(k % 7 + 1), 16'hA000 + 16'(k)});
    end
    ai = 0;
    li = 0;
    for (int c = 0; c < 10; c++) begin
      alu_valid = 1'b1; alu_waddr = AW'(ai % 7 + 1); alu_wdata = 16'hA000 + 16'(ai);
      lsu_valid = 1'b1; lsu_waddr = AW'(li % 7 + 1); lsu_wdata = 16'hB000 + 16'(li);
      #1;
      a_go = alu_ready;
      l_go = lsu_ready;
      tick();
      if (a_go) ai++;
      if (l_go) li++;
    end
    idle();
    tick();
    tick();
    tick();
    check("stats_alu_accepts", ai, 5);
    check("stats_lsu_accepts", li, 6);
`ifdef REGWB_CONFLICT_STATS_EN
    exp_conf = 10;
`else
    exp_conf = 0;
`endif
    check("stats_conflict_cnt", conflict_cnt, exp_conf);
    check("stats_end_pend", pend, 0);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
